booth_mul_scheduler: RTL and testbench

BOOTH_MUL_SCHEDULER -- requirements
Module: booth_mul_scheduler

---
 rtl/booth_mul_scheduler.sv | 151 +++++++++++++++
 tb/tb_booth_mul_scheduler.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_mul_scheduler.sv
// rtl/booth_mul_scheduler.sv - round-robin scheduler feeding a shared sequential Booth multiplier
module booth_mul_scheduler #(
    parameter int N_REQ   = 4,
    parameter int DW      = 16,
    parameter int TIMEOUT = 40,
    localparam int IW     = (N_REQ > 1) ? $clog2(N_REQ) : 1,
    localparam int CW     = $clog2(TIMEOUT + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req,
    input  logic [N_REQ*DW-1:0]   a_in,
    input  logic [N_REQ*DW-1:0]   b_in,
    output logic [N_REQ-1:0]      gnt,
    output logic                  busy,
    output logic                  rsp_valid,
    output logic [IW-1:0]         rsp_id,
    output logic [2*DW-1:0]       rsp_product,
    output logic                  rsp_err,
    output logic                  mul_start,
    output logic [DW-1:0]         mul_data,
    input  logic                  mul_done,
    input  logic [2*DW-1:0]       mul_product
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_M = 3'd1,
        LOAD_Q = 3'd2,
        WAIT   = 3'd3,
        RESP   = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   id_q, id_d;
    logic [DW-1:0]   b_q, b_d;
    logic [DW-1:0]   mul_data_q, mul_data_d;
    logic [CW-1:0]   wait_cnt_q, wait_cnt_d;
    logic [IW-1:0]   rsp_id_q, rsp_id_d;
    logic [2*DW-1:0] rsp_product_q, rsp_product_d;
    logic            rsp_err_q, rsp_err_d;

    logic            win_found;
    logic [IW-1:0]   win_idx;
    int              idx;

    // Search starts one past the last served requester so every requester gets a turn.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        idx       = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(ptr_q) + k) % N_REQ;
            if (!win_found && req[idx]) begin
                win_found = 1'b1;
                win_idx   = IW'(idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            ptr_q         <= IW'(N_REQ - 1);
            id_q          <= '0;
            b_q           <= '0;
            mul_data_q    <= '0;
            wait_cnt_q    <= '0;
            rsp_id_q      <= '0;
            rsp_product_q <= '0;
            rsp_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            id_q          <= id_d;
            b_q           <= b_d;
            mul_data_q    <= mul_data_d;
            wait_cnt_q    <= wait_cnt_d;
            rsp_id_q      <= rsp_id_d;
            rsp_product_q <= rsp_product_d;
            rsp_err_q     <= rsp_err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        id_d          = id_q;
        b_d           = b_q;
        mul_data_d    = mul_data_q;
        wait_cnt_d    = wait_cnt_q;
        rsp_id_d      = rsp_id_q;
        rsp_product_d = rsp_product_q;
        rsp_err_d     = rsp_err_q;
        unique case (state_q)
            IDLE: begin
                if (win_found) begin
                    id_d       = win_idx;
                    mul_data_d = a_in[int'(win_idx)*DW +: DW];
                    b_d        = b_in[int'(win_idx)*DW +: DW];
                    state_d    = LOAD_M;
                end
            end
            LOAD_M: begin
                mul_data_d = b_q;
                state_d    = LOAD_Q;
            end
            LOAD_Q: state_d = WAIT;
            WAIT: begin
                if (mul_done) begin
                    rsp_product_d = mul_product;
                    rsp_err_d     = 1'b0;
                    rsp_id_d      = id_q;
                    state_d       = RESP;
                end else if (wait_cnt_q == CW'(TIMEOUT - 1)) begin
                    // Multiplier never answered: report an error with a zero product.
                    wait_cnt_d    = wait_cnt_q + 1'b1;
                    rsp_product_d = '0;
                    rsp_err_d     = 1'b1;
                    rsp_id_d      = id_q;
                    state_d       = RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            RESP: begin
                ptr_d      = id_q;
                wait_cnt_d = '0;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        gnt       = '0;
        busy      = (state_q != IDLE);
        rsp_valid = (state_q == RESP);
        mul_start = (state_q == LOAD_M);
        if (state_q == IDLE && win_found && !rst) begin
            gnt[win_idx] = 1'b1;
        end
    end

    assign mul_data    = mul_data_q;
    assign rsp_id      = rsp_id_q;
    assign rsp_product = rsp_product_q;
    assign rsp_err     = rsp_err_q;

endmodule

// File: tb/tb_booth_mul_scheduler.sv
// tb/tb_booth_mul_scheduler.sv - scoreboard bench for booth_mul_scheduler
module tb_booth_mul_scheduler;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int TO = 40;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req = '0;
    logic [N*DW-1:0] a_in = '0;
    logic [N*DW-1:0] b_in = '0;
    logic [N-1:0]    gnt;
    logic            busy;
    logic            rsp_valid;
    logic [1:0]      rsp_id;
    logic [31:0]     rsp_product;
    logic            rsp_err;
    logic            mul_start;
    logic [DW-1:0]   mul_data;
    logic            mul_done = 1'b0;
    logic [31:0]     mul_product = '0;

    booth_mul_scheduler #(.N_REQ(N), .DW(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in),
        .gnt(gnt), .busy(busy), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
        .rsp_product(rsp_product), .rsp_err(rsp_err),
        .mul_start(mul_start), .mul_data(mul_data),
        .mul_done(mul_done), .mul_product(mul_product)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [31:0] prod;
        logic        err;
    } exp_t;

    exp_t rq[$];
    int   gq[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   gnt_cnt = 0;
    int   rsp_cnt = 0;
    int   gnt_cyc = 0;
    int   done_cyc = 0;

    int                 mul_lat = 4;
    bit                 hang = 1'b0;
    bit                 inject_done = 1'b0;
    int                 m_phase = 0;
    int                 m_cnt = 0;
    logic signed [15:0] m_a, m_b;

    always @(posedge clk) cyc <= cyc + 1;

    // External multiplier: takes the multiplicand on mul_start, the multiplier next cycle.
    always @(negedge clk) begin
        mul_done = 1'b0;
        if (rst) begin
            m_phase = 0;
        end else if (inject_done) begin
            mul_done    = 1'b1;
            mul_product = 32'h1234_5678;
            inject_done = 1'b0;
        end else if (mul_start) begin
            m_a     = mul_data;
            m_phase = 1;
        end else if (m_phase == 1) begin
            m_b     = mul_data;
            m_cnt   = mul_lat;
            m_phase = 2;
        end else if (m_phase == 2 && !hang) begin
            if (m_cnt == 0) begin
                mul_done    = 1'b1;
                mul_product = 32'(m_a * m_b);
                done_cyc    = cyc;
                m_phase     = 0;
            end else begin
                m_cnt--;
            end
        end
    end

    exp_t e;
    int   eg;
    always @(negedge clk) begin
        if (!rst) begin
            if (gnt != '0) begin
                total++;
                gnt_cnt++;
                gnt_cyc = cyc;
                if (gq.size() == 0) begin
                    bad++;
                    $display("FAIL gnt_unexpected got=%b", gnt);
                end else begin
                    eg = gq.pop_front();
                    if (gnt !== (4'b0001 << eg)) begin
                        bad++;
                        $display("FAIL gnt_order got=%b want=%b", gnt, 4'b0001 << eg);
                    end
                end
            end
            if (rsp_valid) begin
                rsp_cnt++;
                total++;
                if (rq.size() == 0) begin
                    bad++;
                    $display("FAIL rsp_unexpected id=%0d", rsp_id);
                end else begin
                    e = rq.pop_front();
                    if (rsp_id !== 2'(e.id) || rsp_product !== e.prod || rsp_err !== e.err) begin
                        bad++;
                        $display("FAIL rsp_data got id=%0d prod=%h err=%b want id=%0d prod=%h err=%b",
                                 rsp_id, rsp_product, rsp_err, e.id, e.prod, e.err);
                    end
                    total++;
                    if (e.err && cyc !== gnt_cyc + 3 + TO) begin
                        bad++;
                        $display("FAIL rsp_timeout_latency got=%0d want=%0d", cyc - gnt_cyc, 3 + TO);
                    end else if (!e.err && cyc !== done_cyc + 1) begin
                        bad++;
                        $display("FAIL rsp_done_latency got=%0d want=1", cyc - done_cyc);
                    end
                end
            end
        end
    end

    function automatic logic [31:0] exp_prod(input logic signed [15:0] a, input logic signed [15:0] b);
        logic signed [31:0] p;
        p = 32'(a) * 32'(b);
        return p;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rsp(input int target);
        int n = 0;
        while (rsp_cnt < target && n < 2000) begin
            @(negedge clk);
            #1;
            n++;
        end
        total++;
        if (rsp_cnt < target) begin
            bad++;
            $display("FAIL wait_rsp_timeout got=%0d want=%0d", rsp_cnt, target);
        end
    endtask

    task automatic do_reset();
        step();
        rst = 1'b1;
        req = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic issue(input int id, input logic [15:0] a, input logic [15:0] b, input logic [31:0] p);
        int tgt;
        a_in[id*DW +: DW] = a;
        b_in[id*DW +: DW] = b;
        gq.push_back(id);
        rq.push_back('{id, p, 1'b0});
        tgt = rsp_cnt + 1;
        step();
        req = 4'b0001 << id;
        step();
        req = '0;
        wait_rsp(tgt);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = '0;
        step();
        step();
        @(negedge clk);
        total++;
        if ({gnt, busy, rsp_valid, mul_start} !== 7'b0) begin
            bad++;
            $display("FAIL reset_ctrl got gnt=%b busy=%b vld=%b start=%b want 0", gnt, busy, rsp_valid, mul_start);
        end
        total++;
        if ({rsp_id, rsp_product, rsp_err, mul_data} !== 51'b0) begin
            bad++;
            $display("FAIL reset_data got id=%0d prod=%h err=%b data=%h want 0", rsp_id, rsp_product, rsp_err, mul_data);
        end
        step();
        rst = 1'b0;
    endtask

    task automatic test_single();
        int tgt;
        a_in[0 +: DW] = 16'd14;
        b_in[0 +: DW] = 16'hFFF0;
        mul_lat = 17;
        gq.push_back(0);
        rq.push_back('{0, 32'hFFFF_FF20, 1'b0});
        tgt = rsp_cnt + 1;
        step();
        req = 4'b0001;
        @(negedge clk);
        total++;
        if (gnt !== 4'b0001 || busy !== 1'b0) begin
            bad++;
            $display("FAIL single_gnt got gnt=%b busy=%b want 0001 0", gnt, busy);
        end
        step();
        req = '0;
        @(negedge clk);
        total++;
        if (mul_start !== 1'b1 || mul_data !== 16'd14 || busy !== 1'b1) begin
            bad++;
            $display("FAIL single_load_m got start=%b data=%h busy=%b want 1 000e 1", mul_start, mul_data, busy);
        end
        @(negedge clk);
        total++;
        if (mul_start !== 1'b0 || mul_data !== 16'hFFF0) begin
            bad++;
            $display("FAIL single_load_q got start=%b data=%h want 0 fff0", mul_start, mul_data);
        end
        repeat (3) @(negedge clk);
        total++;
        if (mul_data !== 16'hFFF0 || rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL single_wait_hold got data=%h vld=%b want fff0 0", mul_data, rsp_valid);
        end
        wait_rsp(tgt);
        @(negedge clk);
        total++;
        if (rsp_valid !== 1'b0 || rsp_product !== 32'hFFFF_FF20 || mul_data !== 16'hFFF0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL single_hold got vld=%b prod=%h data=%h busy=%b want 0 ffffff20 fff0 0",
                     rsp_valid, rsp_product, mul_data, busy);
        end
        mul_lat = 4;
    endtask

    task automatic test_round_robin();
        int start, tgt, n;
        do_reset();
        for (int i = 0; i < N; i++) begin
            a_in[i*DW +: DW] = 16'(100 * i + 3);
            b_in[i*DW +: DW] = 16'(-(3 * i + 5));
        end
        for (int k = 0; k < 5; k++) begin
            gq.push_back(k % N);
            rq.push_back('{k % N, exp_prod(16'(100 * (k % N) + 3), 16'(-(3 * (k % N) + 5))), 1'b0});
        end
        start = gnt_cnt;
        tgt = rsp_cnt + 5;
        n = 0;
        step();
        req = 4'b1111;
        while (gnt_cnt < start + 5 && n < 1000) begin
            @(negedge clk);
            #1;
            n++;
        end
        step();
        req = '0;
        total++;
        if (gnt_cnt !== start + 5) begin
            bad++;
            $display("FAIL rr_grant_count got=%0d want=%0d", gnt_cnt - start, 5);
        end
        wait_rsp(tgt);
    endtask

    task automatic test_midop_reset();
        int c;
        hang = 1'b1;
        a_in[0 +: DW] = 16'd9;
        b_in[0 +: DW] = 16'd9;
        gq.push_back(0);
        step();
        req = 4'b0001;
        step();
        req = '0;
        repeat (5) @(negedge clk);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        total++;
        if ({gnt, busy, rsp_valid, mul_start, rsp_id, rsp_product, rsp_err, mul_data} !== 58'b0) begin
            bad++;
            $display("FAIL midop_reset_outputs got gnt=%b busy=%b vld=%b start=%b id=%0d prod=%h err=%b data=%h want 0",
                     gnt, busy, rsp_valid, mul_start, rsp_id, rsp_product, rsp_err, mul_data);
        end
        hang = 1'b0;
        c = rsp_cnt;
        inject_done = 1'b1;
        repeat (4) @(negedge clk);
        total++;
        if (rsp_cnt !== c) begin
            bad++;
            $display("FAIL midop_stray_done got rsp=%0d want=%0d", rsp_cnt - c, 0);
        end
        issue(2, 16'd300, 16'hFFFD, 32'hFFFF_FC7C);
    endtask

    task automatic test_timeout();
        int tgt;
        hang = 1'b1;
        a_in[1*DW +: DW] = 16'd7;
        b_in[1*DW +: DW] = 16'd9;
        gq.push_back(1);
        rq.push_back('{1, 32'h0, 1'b1});
        tgt = rsp_cnt + 1;
        step();
        req = 4'b0010;
        step();
        req = '0;
        wait_rsp(tgt);
        hang = 1'b0;
        issue(1, 16'd7, 16'd9, 32'd63);
    endtask

    task automatic test_corner();
        issue(3, 16'h8000, 16'h8000, 32'h4000_0000);
        issue(0, 16'h0000, 16'd12345, 32'h0);
        issue(2, 16'h7FFF, 16'h8000, 32'hC000_8000);
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_midop_reset();
        test_timeout();
        test_corner();
        repeat (3) @(negedge clk);
        total++;
        if (rq.size() !== 0 || gq.size() !== 0) begin
            bad++;
            $display("FAIL leftover_expectations got rsp=%0d gnt=%0d want 0 0", rq.size(), gq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
